// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter with a byte FIFO and a programmable baud divisor.
// Defining UART_TX_PARITY_EN adds an even-parity bit to every frame (8E1).
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        HIT,
    output logic        TX
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic [15:0]      div_r;
    state_t           state_r;
    logic [7:0]       shift_r;
    logic             parity_r;
    logic [15:0]      bit_div_r;
    logic [15:0]      bit_cnt_r;
    logic [2:0]       bit_idx_r;
    logic             tx_r;

    logic        hit_s;
    logic        wr_data_s;
    logic        wr_status_s;
    logic        wr_div_s;
    logic        full_s;
    logic        empty_s;
    logic        pop_s;
    logic        push_s;
    logic        push_ok_s;
    logic [7:0]  head_s;
    logic [31:0] status_s;

    assign hit_s       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]) && (IOBUS_ADDR[3:2] != 2'b11);
    assign wr_data_s   = IOBUS_WR && hit_s && (IOBUS_ADDR[3:2] == 2'b00);
    assign wr_status_s = IOBUS_WR && hit_s && (IOBUS_ADDR[3:2] == 2'b01);
    assign wr_div_s    = IOBUS_WR && hit_s && (IOBUS_ADDR[3:2] == 2'b10);
    assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign pop_s       = (state_r == IDLE) && !empty_s;
    assign push_s      = wr_data_s;
    // A push into a full FIFO is still accepted when the FSM frees a slot in the same cycle
    assign push_ok_s   = push_s && (!full_s || pop_s);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign status_s    = {16'h0000, 8'(count_r), 3'b000, PARITY_FLAG,
                          overflow_r, empty_s, full_s, (state_r != IDLE)};
    assign HIT         = hit_s;
    assign TX          = tx_r;

    // Read mux: zero unless the address hits a mapped register
    always_comb begin
        RD_DATA = 32'h0000_0000;
        if (hit_s) begin
            case (IOBUS_ADDR[3:2])
                2'b01:   RD_DATA = status_s;
                2'b10:   RD_DATA = {16'h0000, div_r};
                default: RD_DATA = 32'h0000_0000;
            endcase
        end else begin
            RD_DATA = 32'h0000_0000;
        end
    end

    // FIFO storage (contents are don't-care until written)
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= IOBUS_OUT[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (wr_status_s && IOBUS_OUT[3]) begin
                overflow_r <= 1'b0;
            end else if (push_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Baud divisor register; values below 2 would break bit timing
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            div_r <= DIV_DEFAULT;
        end else if (wr_div_s) begin
            div_r <= (IOBUS_OUT[15:0] < 16'd2) ? 16'd2 : IOBUS_OUT[15:0];
        end
    end

    // Bit-timing FSM; the divisor is latched per frame so mid-frame DIV writes wait
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r   <= IDLE;
            tx_r      <= 1'b1;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            bit_div_r <= DIV_DEFAULT;
            bit_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        shift_r   <= head_s;
                        parity_r  <= even_parity(head_s);
                        bit_div_r <= div_r;
                        bit_cnt_r <= div_r - 16'd1;
                        tx_r      <= 1'b0;
                        state_r   <= START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt_r == 16'd0) begin
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[7:1]};
                        bit_cnt_r <= bit_div_r - 16'd1;
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt_r == 16'd0) begin
                        bit_cnt_r <= bit_div_r - 16'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_r    <= parity_r;
                            state_r <= PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_cnt_r == 16'd0) begin
                        tx_r      <= 1'b1;
                        bit_cnt_r <= bit_div_r - 16'd1;
                        state_r   <= STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
`endif
                STOP: begin
                    tx_r <= 1'b1;
                    if (bit_cnt_r == 16'd0) begin
                        state_r <= IDLE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iobus_uart_tx.sv
// Randomized bench for iobus_uart_tx against a frame-schedule reference model.
module tb_iobus_uart_tx;
    localparam logic [31:0] BASE  = 32'h1100_0100;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int   NBITS = 11;
    localparam logic PAR   = 1'b1;
`else
    localparam int   NBITS = 10;
    localparam logic PAR   = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] IOBUS_ADDR = 32'h0;
    logic [31:0] IOBUS_OUT = 32'h0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] RD_DATA;
    logic        HIT;
    logic        TX;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic [15:0] m_div;
    logic        f_act;
    logic [10:0] f_bits;
    int          f_div;
    int          f_pos;

    iobus_uart_tx dut (
        .CLK(CLK), .RESET_N(RESET_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA), .HIT(HIT), .TX(TX)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'h0;
        s[0]    = f_act;
        s[1]    = (m_q.size() == DEPTH);
        s[2]    = (m_q.size() == 0);
        s[3]    = m_ovf;
        s[4]    = PAR;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        if (a[3:2] == 2'b01) return m_status();
        if (a[3:2] == 2'b10) return {16'h0, m_div};
        return 32'h0;
    endfunction

    function automatic logic m_tx();
        if (!f_act) return 1'b1;
        return f_bits[f_pos / f_div];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_div = 16'd434;
        f_act = 1'b0;
        f_pos = 0;
        f_div = 1;
        f_bits = 11'h7FF;
    endtask

    // one clock edge of the reference: frame schedule advances, then the bus write lands
    task automatic model_update(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                input logic rst);
        int  sz;
        bit  pop;
        logic [7:0] b;
        if (!rst) begin
            model_reset();
            return;
        end
        sz  = m_q.size();
        pop = 1'b0;
        if (f_act) begin
            f_pos++;
            if (f_pos == NBITS * f_div) f_act = 1'b0;
        end else if (sz > 0) begin
            b = m_q.pop_front();
            pop = 1'b1;
            f_act = 1'b1;
            f_pos = 0;
            f_div = int'(m_div);
            f_bits = 11'h7FF;
            f_bits[0] = 1'b0;
            f_bits[8:1] = b;
            if (PAR) f_bits[9] = ^b;
        end
        if (wr && m_hit(a)) begin
            case (a[3:2])
                2'b00: begin
                    if (sz == DEPTH && !pop) m_ovf = 1'b1;
                    else m_q.push_back(d[7:0]);
                end
                2'b01: if (d[3]) m_ovf = 1'b0;
                2'b10: m_div = (d[15:0] < 16'd2) ? 16'd2 : d[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic rst);
        @(negedge CLK);
        RESET_N = rst; IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d;
        #1;
        check("hit", {31'h0, HIT}, {31'h0, m_hit(a)});
        check("rd_data", RD_DATA, m_read(a));
        check("tx", {31'h0, TX}, {31'h0, m_tx()});
        @(posedge CLK);
        model_update(wr, a, d, rst);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, BASE + 32'h4, 32'h0, 1'b1);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        step(1'b1, BASE + off, d, 1'b1);
    endtask

    // mid-cycle read of a register against a fixed expected value
    task automatic peek(input string tag, input logic [31:0] off, input logic [31:0] exp);
        #2;
        IOBUS_WR = 1'b0;
        IOBUS_ADDR = BASE + off;
        #1;
        check(tag, RD_DATA, exp);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((f_act || m_q.size() > 0) && g < 20000) begin
            idle(1);
            g++;
        end
        check("drain_bound", {31'h0, (g < 20000)}, 32'h1);
        idle(2);
    endtask

    initial begin
        logic [31:0] off, d;
        int r;
        bit after_rst;
        model_reset();
        repeat (2) @(posedge CLK);
        idle(2);
        peek("rst_status", 32'h4, {27'h0, PAR, 4'h4});
        peek("rst_div", 32'h8, 32'd434);
        check("rst_tx", {31'h0, TX}, 32'h1);

        // single frame at DIV=4
        wr(32'h8, 32'd4);
        wr(32'h0, 32'hA5);
        idle(48);
        peek("a5_status", 32'h4, {27'h0, PAR, 4'h4});

        // overflow while the FSM is busy on a frame
        wr(32'h8, 32'd2);
        wr(32'h0, 32'h00);
        idle(2);
        for (int i = 1; i <= 9; i++) wr(32'h0, i);
        peek("ovf_status", 32'h4, {16'h0, 8'd8, 3'b000, PAR, 4'hB});
        drain();
        wr(32'h4, 32'h8);
        peek("ovf_clear", 32'h4, {27'h0, PAR, 4'h4});

        // DIV clamping and mid-frame DIV change
        wr(32'h8, 32'd1);
        peek("div_clamp", 32'h8, 32'd2);
        wr(32'h0, 32'h3C);
        idle(5);
        wr(32'h8, 32'h1234_0008);
        peek("div_hi_ignored", 32'h8, 32'd8);
        wr(32'h0, 32'h5A);
        drain();

        // reset during data bit 3
        wr(32'h8, 32'd4);
        wr(32'h0, 32'hC3);
        wr(32'h0, 32'h81);
        idle(17);
        step(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        peek("midrst_status", 32'h4, {27'h0, PAR, 4'h4});
        check("midrst_tx", {31'h0, TX}, 32'h1);
        wr(32'h8, 32'd4);
        idle(20);

        // parity-sensitive frame
        wr(32'h0, 32'h07);
        drain();

        // randomized traffic
        after_rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (after_rst) begin
                wr(32'h8, 32'd3);
                after_rst = 1'b0;
            end else if (r < 2) begin
                step(1'b0, BASE + 32'h4, 32'h0, 1'b0);
                after_rst = 1'b1;
            end else if (r < 30) begin
                off = {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                d = $urandom();
                if (off[3:2] == 2'b10) d = {d[31:16], 16'($urandom_range(0, 6))};
                if ($urandom_range(0, 7) == 0) off = off + 32'h10;
                wr(off, d);
            end else begin
                off = {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                step(1'b0, BASE + off, $urandom(), 1'b1);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/iobus_uart_tx.md
Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter acting as a responder on the MCU's IOBUS; the MCU is the initiator.
- The MCU writes bytes into an internal FIFO. A bit-timing state machine serializes them 8N1, LSB first, onto the TX pin.
- Status and baud divisor are readable through the IOBUS read path. This is the transmit counterpart of the serial programmer's receive side.

Parameters:
- BASE_ADDR, 32'h1100_0100, byte address of register 0. Registers are word-spaced.
- FIFO_DEPTH, 8, FIFO entries; power of 2, range 2..64.
- DIV_DEFAULT, 434, reset value of the baud divisor (clocks per bit); 50 MHz / 115200.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous, active-low reset.
- IOBUS_ADDR  in  32  byte address from the MCU.
- IOBUS_OUT  in  32  MCU write data.
- IOBUS_WR  in  1  MCU write strobe; one-cycle pulse per store.
- RD_DATA  out  32  read data, muxed into the MCU's IOBUS_IN at top level.
- HIT  out  1  high when IOBUS_ADDR[31:4] matches BASE_ADDR[31:4] and IOBUS_ADDR[3:2] is not 2'b11.
- TX  out  1  serial output; idle high; driven directly from a flop.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x0 DATA: write pushes IOBUS_OUT[7:0]; reads as 0.
  - 0x4 STATUS, read-only except bit3: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[15:8] FIFO count, other bits 0.
  - 0x8 DIV: read/write, bits[15:0]. Bits above 15 are ignored on write and read as 0.
- A write is any cycle with IOBUS_WR=1 and HIT=1, decoded on IOBUS_ADDR[3:2]. IOBUS_ADDR[1:0] is ignored. Writes with HIT=0 have no effect.
- STATUS write with IOBUS_OUT[3]=1 clears overflow. Other STATUS bits are unaffected.
- DIV writes of 0 or 1 store 2.
- RD_DATA is combinational from IOBUS_ADDR over registered state. It is 0 when HIT=0.
- FIFO:
  - Circular, with read/write pointers that wrap modulo FIFO_DEPTH and a count of width log2(FIFO_DEPTH)+1.
  - Push when full: byte dropped, overflow set, pointers and count unchanged.
  - Simultaneous push and pop in one cycle: both take effect and count is unchanged. This includes the full case: a push while full and a pop in the same cycle is accepted, not an overflow.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, latch DIV into the bit divisor, load the bit counter with divisor-1, and go to START.
  - START: TX=0 for divisor cycles, then DATA.
  - DATA: TX=shift[0] for divisor cycles per bit, shifting right. After 8 bits, go to STOP.
  - STOP: TX=1 for divisor cycles, then IDLE. The next frame may start on the following edge.
- Frame length is 10*divisor cycles. Back-to-back frames have exactly 1 extra idle cycle between the stop bit and the next start bit.
- A DIV change mid-frame takes effect only at the next frame start.
- Latency: a DATA write captured at edge k into an empty FIFO with the FSM in IDLE causes TX to fall at edge k+1.
- Reset (RESET_N=0 at a clock edge), including mid-frame:
  - TX=1, FSM=IDLE, FIFO empty, pointers 0, overflow 0, DIV=DIV_DEFAULT.
  - The partial frame is abandoned.
  - RD_DATA and HIT remain combinational from IOBUS_ADDR over the reset state.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for divisor cycles.
  - Frame length is 11*divisor cycles.
  - STATUS bit4 reads 1.
- Undefined: no PARITY state; 8N1; STATUS bit4 reads 0.

Test Plan:
- Reset, then read BASE+0x4 and BASE+0x8 -> STATUS=0x0000_0004, DIV=434, TX=1.
- Write DIV=4, then DATA=0xA5 -> TX samples at 4-cycle spacing: 0,1,0,1,0,0,1,0,1,1; busy=1 for 40 cycles; then STATUS=0x4.
- With DIV=2 and the FSM stalled on a frame, write 9 bytes 0x01..0x09 rapidly -> the 9th write sets overflow and the count stays 8. Frames then emit 0x01..0x08 in order, with exactly 1 idle cycle between frames. Writing STATUS=0x8 clears overflow.
- Write DIV=1 -> reads back 2. Write DIV=8 mid-frame -> the current frame keeps the old bit width; the next frame uses 8 cycles per bit.
- Assert RESET_N=0 for one cycle during DATA bit 3 -> TX=1 on the next edge, STATUS=0x4, no further frames are sent.
- With UART_TX_PARITY_EN defined, DIV=4, DATA=0x07 -> after the data bits, parity bit 1 for 4 cycles, then stop; frame is 44 cycles; STATUS bit4=1.
